// File: rtl/window_inserter.sv
// window_inserter: re-embeds a cropped window pixel stream into a full
// background raster at a fixed offset. Window pixels are buffered in a
// show-ahead FIFO and drained while the background raster is inside the
// window region. Output is registered (1-cycle latency).
module window_inserter #(
  parameter int IW       = 640,
  parameter int IH       = 480,
  parameter int DW       = 8,
  parameter int COUPER_W = 256,
  parameter int COUPER_V = 256,
  parameter int HL_ZONE  = 192,
  parameter int VU_ZONE  = 112,
  parameter int FIFO_AW  = 9,
  parameter logic [DW-1:0] FILL = 8'hdd
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_vs,
  input  logic              per_de,
  input  logic [DW-1:0]     per_data,
  input  logic              win_de,
  input  logic [DW-1:0]     win_data,
  output logic              post_vs,
  output logic              post_de,
  output logic [DW-1:0]     post_data,
  output logic              ovf,
  output logic              udf,
  output logic [FIFO_AW:0]  fifo_level
);

  localparam int DEPTH = 1 << FIFO_AW;

  // Window bounds in counter width; the high bounds are exclusive.
  localparam logic [15:0] H_LO   = 16'(HL_ZONE);
  localparam logic [15:0] H_HI   = 16'(HL_ZONE + COUPER_W);
  localparam logic [15:0] V_LO   = 16'(VU_ZONE);
  localparam logic [15:0] V_HI   = 16'(VU_ZONE + COUPER_V);
  localparam logic [15:0] H_LAST = 16'(IW - 1);
  localparam logic [15:0] V_LAST = 16'(IH - 1);
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

  logic                per_vs_d_reg;
  logic [15:0]         hcnt_reg;
  logic [15:0]         vcnt_reg;
  logic [FIFO_AW-1:0]  wr_ptr_reg;
  logic [FIFO_AW-1:0]  rd_ptr_reg;
  logic [FIFO_AW:0]    level_reg;
  logic                ovf_reg;
  logic                udf_reg;
  logic [DW-1:0]       mem [DEPTH];

  logic                pose;
  logic                in_win;
  logic                fifo_empty;
  logic                fifo_full;
  logic                pop_ok;
  logic                push_ok;
  logic [DW-1:0]       head_word;

  assign pose       = per_vs & ~per_vs_d_reg;
  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == LVL_FULL);

  // Region test uses the counters before this cycle's update.
  assign in_win = per_de
                  && (hcnt_reg >= H_LO) && (hcnt_reg < H_HI)
                  && (vcnt_reg >= V_LO) && (vcnt_reg < V_HI);

  // A pop only moves the read side when there is data; the frame flush on
  // pose overrides all FIFO traffic, including a push on that same cycle.
  assign pop_ok  = in_win & ~fifo_empty & ~pose;
  assign push_ok = win_de & ~pose & (~fifo_full | pop_ok);

  // Show-ahead head word: combinational read of the read pointer.
  assign head_word = mem[rd_ptr_reg];

  // Raster position tracking: edge detect, column and line counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per_vs_d_reg <= 1'b0;
      hcnt_reg     <= '0;
      vcnt_reg     <= '0;
    end else begin
      per_vs_d_reg <= per_vs;
      if (per_de) begin
        hcnt_reg <= (hcnt_reg == H_LAST) ? '0 : hcnt_reg + 16'd1;
      end else begin
        hcnt_reg <= '0;
      end
      if (pose) begin
        vcnt_reg <= '0;
      end else if (per_de && (hcnt_reg == H_LAST)) begin
        vcnt_reg <= (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 16'd1;
      end
    end
  end

  // FIFO pointers and occupancy; flushed at every frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (pose) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // FIFO storage write port (no reset so it maps onto RAM).
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem[wr_ptr_reg] <= win_data;
    end
  end

  // Sticky per-frame error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else if (pose) begin
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_reg | (win_de & ~push_ok);
      udf_reg <= udf_reg | (in_win & fifo_empty);
    end
  end

  // Registered compositing of window/fill/background and sync delay.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      post_vs   <= 1'b0;
      post_de   <= 1'b0;
      post_data <= '0;
    end else begin
      post_vs <= per_vs;
      post_de <= per_de;
      if (in_win) begin
        post_data <= fifo_empty ? FILL : head_word;
      end else begin
        post_data <= per_data;
      end
    end
  end

  assign ovf        = ovf_reg;
  assign udf        = udf_reg;
  assign fifo_level = level_reg;

endmodule

// File: tb/tb_window_inserter.sv
// Testbench for window_inserter: directed frames plus randomized frames,
// checked cycle by cycle against a queue-based reference model.
module tb_window_inserter;

  localparam int IW = 16;
  localparam int IH = 8;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int CV = 2;
  localparam int HL = 6;
  localparam int VU = 3;
  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;
  localparam logic [7:0] FILL = 8'hdd;
  localparam int HBLANK = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          per_vs;
  logic          per_de;
  logic [DW-1:0] per_data;
  logic          win_de;
  logic [DW-1:0] win_data;
  logic          post_vs;
  logic          post_de;
  logic [DW-1:0] post_data;
  logic          ovf;
  logic          udf;
  logic [AW:0]   fifo_level;

  window_inserter #(
    .IW(IW), .IH(IH), .DW(DW), .COUPER_W(CW), .COUPER_V(CV),
    .HL_ZONE(HL), .VU_ZONE(VU), .FIFO_AW(AW), .FILL(FILL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .per_vs(per_vs), .per_de(per_de), .per_data(per_data),
    .win_de(win_de), .win_data(win_data),
    .post_vs(post_vs), .post_de(post_de), .post_data(post_data),
    .ovf(ovf), .udf(udf), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: FIFO contents as a queue, sticky flags, last vs.
  logic [7:0] q[$];
  logic       ovf_m;
  logic       udf_m;
  logic       vs_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; line/col give the raster position the bench drives.
  task automatic step(input logic vs, input logic de, input logic [7:0] pd,
                      input logic wde, input logic [7:0] wd,
                      input int line, input int col, input logic rst);
    logic [7:0] exp_data;
    logic exp_vs, exp_de, pose, in_win, empty, full, pop_ok, acc;
    per_vs   = vs;
    per_de   = de;
    per_data = pd;
    win_de   = wde;
    win_data = wd;
    rst_n    = ~rst;
    if (rst) begin
      q.delete();
      ovf_m = 1'b0; udf_m = 1'b0; vs_prev = 1'b0;
      exp_data = 8'h00; exp_vs = 1'b0; exp_de = 1'b0;
    end else begin
      pose   = vs & ~vs_prev;
      in_win = de && line >= VU && line < VU + CV && col >= HL && col < HL + CW;
      empty  = (q.size() == 0);
      exp_data = in_win ? (empty ? FILL : q[0]) : pd;
      if (pose) begin
        q.delete();
        ovf_m = 1'b0; udf_m = 1'b0;
      end else begin
        full   = (q.size() == DEPTH);
        pop_ok = in_win && !empty;
        acc    = wde && (!full || pop_ok);
        if (pop_ok) void'(q.pop_front());
        if (in_win && empty) udf_m = 1'b1;
        if (acc) q.push_back(wd);
        else if (wde) ovf_m = 1'b1;
      end
      vs_prev = vs;
      exp_vs = vs;
      exp_de = de;
    end
    @(posedge clk);
    #1;
    $display("t=%0t vs=%0b de=%0b L%0d C%0d wde=%0b -> data=%02h lvl=%0d ovf=%0b udf=%0b",
             $time, vs, de, line, col, wde, post_data, fifo_level, ovf, udf);
    chk("post_data",  32'(post_data),  32'(exp_data));
    chk("post_vs",    32'(post_vs),    32'(exp_vs));
    chk("post_de",    32'(post_de),    32'(exp_de));
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    chk("ovf",        32'(ovf),        32'(ovf_m));
    chk("udf",        32'(udf),        32'(udf_m));
  endtask

  function automatic logic [7:0] bg(input bit zero_bg);
    return zero_bg ? 8'h00 : 8'($urandom);
  endfunction

  // A complete frame: pose (with a push that must be discarded), npre
  // pre-window pushes, IH lines with blanking, then npost trailing pushes.
  task automatic frame(input int npre, input int npost, input int pct,
                       input bit zero_bg, input bit push_in_win,
                       input int rst_line, input int rst_col);
    logic wde, inw;
    step(1'b1, 1'b0, bg(zero_bg), 1'b1, 8'hee, -1, -1, 1'b0);
    for (int i = 0; i < npre; i++)
      step(1'b0, 1'b0, bg(zero_bg), 1'b1, 8'(8'h10 + i), -1, -1, 1'b0);
    for (int ln = 0; ln < IH; ln++) begin
      for (int c = 0; c < IW; c++) begin
        inw = (ln >= VU && ln < VU + CV && c >= HL && c < HL + CW);
        wde = push_in_win ? inw : ($urandom_range(99) < pct);
        if (ln == rst_line && c == rst_col) begin
          step(1'b0, 1'b1, bg(zero_bg), wde, 8'($urandom), ln, c, 1'b1);
          step(1'b0, 1'b0, bg(zero_bg), 1'b0, 8'h00, -1, -1, 1'b0);
          step(1'b0, 1'b0, bg(zero_bg), 1'b0, 8'h00, -1, -1, 1'b0);
          return;
        end
        step(1'b0, 1'b1, bg(zero_bg), wde, 8'($urandom), ln, c, 1'b0);
      end
      for (int b = 0; b < HBLANK; b++)
        step(1'b0, 1'b0, bg(zero_bg), ($urandom_range(99) < pct), 8'($urandom), -1, -1, 1'b0);
    end
    for (int i = 0; i < npost; i++)
      step(1'b0, 1'b0, bg(zero_bg), 1'b1, 8'(8'h30 + i), -1, -1, 1'b0);
    step(1'b0, 1'b0, bg(zero_bg), 1'b0, 8'h00, -1, -1, 1'b0);
  endtask

  initial begin
    per_vs = 1'b0; per_de = 1'b0; per_data = '0;
    win_de = 1'b0; win_data = '0; rst_n = 1'b0;
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 8'($urandom), 1'b1, 8'h55, -1, -1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, -1, -1, 1'b0);

    frame(8,  0, 0, 1'b1, 1'b0, -1, -1);   // basic insert
    frame(5,  0, 0, 1'b1, 1'b0, -1, -1);   // underflow
    frame(10, 0, 0, 1'b1, 1'b0, -1, -1);   // overflow
    frame(8,  0, 0, 1'b0, 1'b1, -1, -1);   // full push+pop during window
    frame(10, 3, 0, 1'b0, 1'b0, -1, -1);   // leaves 3 words with ovf set
    frame(8,  0, 0, 1'b0, 1'b0, 3, 7);     // new frame flush, then reset mid-window
    frame(8,  0, 0, 1'b0, 1'b0, -1, -1);   // recovery after reset
    for (int k = 0; k < 6; k++)
      frame($urandom_range(12), $urandom_range(3), 30, 1'b0, 1'b0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
